// File: rtl/br_commit_queue_if.sv
// br_commit_queue_if
//   Bundles the fetch-side, commit-side and predictor-side signals of the
//   branch commit queue.
//   master : fetch/commit logic driving the queue (drives flush_, br_*, com_*)
//   slave  : the queue itself (drives br_commit_, br_taken_, br_pred_miss_,
//            br_com_addr, full, err)
//   Fetch/commit/flush valids are active-low, matching the predictor interface.
interface br_commit_queue_if #(
   parameter int ADDR     = 32,
   parameter int SIMBRF   = 2,
   parameter int SIMBRCOM = 2
);
   logic                     flush_;
   logic [SIMBRF-1:0]        br_;
   logic [SIMBRF*ADDR-1:0]   br_addr;
   logic [SIMBRF-1:0]        pred_taken;
   logic [SIMBRCOM-1:0]      com_br_;
   logic [SIMBRCOM-1:0]      com_taken;
   logic [SIMBRCOM-1:0]      br_commit_;
   logic [SIMBRCOM-1:0]      br_taken_;
   logic [SIMBRCOM-1:0]      br_pred_miss_;
   logic [SIMBRCOM*ADDR-1:0] br_com_addr;
   logic                     full;
   logic                     err;

   modport master (
      output flush_, br_, br_addr, pred_taken, com_br_, com_taken,
      input  br_commit_, br_taken_, br_pred_miss_, br_com_addr, full, err
   );

   modport slave (
      input  flush_, br_, br_addr, pred_taken, com_br_, com_taken,
      output br_commit_, br_taken_, br_pred_miss_, br_com_addr, full, err
   );
endinterface

// File: rtl/br_commit_queue.sv
// br_commit_queue
//   In-order queue of fetched branches {addr, predicted direction}. Retiring
//   branches are paired with the oldest entries and reported to the predictor
//   one cycle later as commit / actual-taken / mispredict pulses.
// Ports:
//   clk     : rising-edge clock
//   reset_  : asynchronous active-low reset
//   bus     : br_commit_queue_if.slave
//             in : flush_, br_, br_addr, pred_taken, com_br_, com_taken
//             out: br_commit_, br_taken_, br_pred_miss_, br_com_addr (registered),
//                  full (from registered count), err (sticky)
module br_commit_queue #(
   parameter int ADDR     = 32,
   parameter int SIMBRF   = 2,
   parameter int SIMBRCOM = 2,
   parameter int DEPTH    = 16
) (
   input  logic             clk,
   input  logic             reset_,
   br_commit_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Entry storage; no reset needed, validity is tracked by the pointers.
   logic [ADDR-1:0] addr_mem [DEPTH];
   logic            pred_mem [DEPTH];

   logic [PW-1:0]            head_reg, head_next;
   logic [PW-1:0]            tail_reg, tail_next;
   logic [CW-1:0]            count_reg, count_next;
   logic [SIMBRCOM-1:0]      commit_reg, commit_next;
   logic [SIMBRCOM-1:0]      taken_reg, taken_next;
   logic [SIMBRCOM-1:0]      miss_reg, miss_next;
   logic [SIMBRCOM*ADDR-1:0] addr_reg, addr_next;
   logic                     err_reg, err_next;

   logic [SIMBRF-1:0]   br_act;
   logic [CW-1:0]       push_n;
   logic [PW-1:0]       wr_off [SIMBRF];
   logic [SIMBRCOM-1:0] com_act;
   logic [CW-1:0]       run_n;
   logic [CW-1:0]       take_n;
   logic                run_live;
   logic                gap_err, under_err, over_err;
   logic                full_int, push_ok, flushing;

   assign br_act   = ~bus.br_;
   assign com_act  = ~bus.com_br_;
   assign flushing = ~bus.flush_;
   assign full_int = count_reg > CW'(DEPTH - SIMBRF);

   // Compress fetch lanes: each active lane lands at tail + (active lanes below it).
   always_comb begin
      push_n = '0;
      for (int i = 0; i < SIMBRF; i++) begin
         wr_off[i] = push_n[PW-1:0];
         push_n    = push_n + CW'(br_act[i]);
      end
   end

   // Only the leading contiguous run of retiring lanes is honoured; any active
   // lane after a gap is a protocol violation.
   always_comb begin
      run_n    = '0;
      run_live = 1'b1;
      gap_err  = 1'b0;
      for (int i = 0; i < SIMBRCOM; i++) begin
         if (com_act[i]) begin
            if (run_live) run_n = run_n + CW'(1);
            else          gap_err = 1'b1;
         end else begin
            run_live = 1'b0;
         end
      end
   end

   assign under_err = run_n > count_reg;
   assign take_n    = under_err ? count_reg : run_n;

   // Pushes are all-or-nothing; a flush silently discards them.
   assign push_ok  = !flushing && !full_int && (push_n != '0);
   assign over_err = !flushing &&  full_int && (push_n != '0);

   // Commits in a flush cycle still retire (they precede the flush point);
   // everything else is discarded by collapsing head onto tail.
   assign head_next  = flushing ? tail_reg : head_reg + take_n[PW-1:0];
   assign tail_next  = tail_reg + (push_ok ? push_n[PW-1:0] : '0);
   assign count_next = flushing ? '0 : count_reg - take_n + (push_ok ? push_n : '0);
   assign err_next   = err_reg | gap_err | under_err | over_err;

   // Per commit lane: pair with entry head+gi, reading pre-edge contents.
   for (genvar gi = 0; gi < SIMBRCOM; gi++) begin : g_rd
      logic [PW-1:0] rd_ptr;
      logic          lane_take;
      assign rd_ptr          = head_reg + PW'(gi);
      assign lane_take       = CW'(gi) < take_n;
      assign commit_next[gi] = ~lane_take;
      assign taken_next[gi]  = lane_take ? ~bus.com_taken[gi] : 1'b1;
      assign miss_next[gi]   = lane_take ? ~(pred_mem[rd_ptr] ^ bus.com_taken[gi]) : 1'b1;
      assign addr_next[gi*ADDR +: ADDR] = lane_take ? addr_mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         for (int i = 0; i < SIMBRF; i++) begin
            if (br_act[i]) begin
               addr_mem[tail_reg + wr_off[i]] <= bus.br_addr[i*ADDR +: ADDR];
               pred_mem[tail_reg + wr_off[i]] <= bus.pred_taken[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
         commit_reg <= '1;
         taken_reg  <= '1;
         miss_reg   <= '1;
         addr_reg   <= '0;
         err_reg    <= 1'b0;
      end else begin
         head_reg   <= head_next;
         tail_reg   <= tail_next;
         count_reg  <= count_next;
         commit_reg <= commit_next;
         taken_reg  <= taken_next;
         miss_reg   <= miss_next;
         addr_reg   <= addr_next;
         err_reg    <= err_next;
      end
   end

   assign bus.br_commit_    = commit_reg;
   assign bus.br_taken_     = taken_reg;
   assign bus.br_pred_miss_ = miss_reg;
   assign bus.br_com_addr   = addr_reg;
   assign bus.full          = full_int;
   assign bus.err           = err_reg;
endmodule

// File: tb/tb_br_commit_queue.sv
// tb_br_commit_queue
//   Self-checking bench for br_commit_queue (ADDR=32, 2 fetch lanes, 2 commit
//   lanes, 16 entries). A behavioural FIFO model predicts each cycle's outputs,
//   which are queued and compared one cycle after the stimulus is applied.
module tb_br_commit_queue;
   localparam int ADDR     = 32;
   localparam int SIMBRF   = 2;
   localparam int SIMBRCOM = 2;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic reset_ = 1'b0;

   br_commit_queue_if #(.ADDR(ADDR), .SIMBRF(SIMBRF), .SIMBRCOM(SIMBRCOM)) bus ();

   br_commit_queue #(.ADDR(ADDR), .SIMBRF(SIMBRF), .SIMBRCOM(SIMBRCOM), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  c;
      logic [1:0]  t;
      logic [1:0]  m;
      logic [63:0] a;
      logic        fl;
      logic        er;
   } exp_t;

   logic [31:0] mq_a [$];
   logic        mq_p [$];
   logic        m_err;
   exp_t        exp_q [$];

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Apply one cycle of stimulus, predict the outputs after the edge, and wait
   // until 1 time unit past that edge.
   task automatic drive(input logic [1:0] br, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] pt, input logic [1:0] cb, input logic [1:0] ct,
                        input logic fl);
      exp_t e;
      int   krun, k, n;
      logic full_pre;
      bus.br_        = br;
      bus.br_addr    = {a1, a0};
      bus.pred_taken = pt;
      bus.com_br_    = cb;
      bus.com_taken  = ct;
      bus.flush_     = fl;
      e.c = 2'b11; e.t = 2'b11; e.m = 2'b11; e.a = '0;
      full_pre = mq_a.size() > DEPTH - SIMBRF;
      krun = (cb[0] == 1'b0) ? ((cb[1] == 1'b0) ? 2 : 1) : 0;
      if (cb[0] == 1'b1 && cb[1] == 1'b0) m_err = 1'b1;
      k = krun;
      if (krun > mq_a.size()) begin
         k = mq_a.size();
         m_err = 1'b1;
      end
      for (int i = 0; i < k; i++) begin
         logic [31:0] ad;
         logic        p;
         logic        mispredicted;
         ad = mq_a.pop_front();
         p  = mq_p.pop_front();
         mispredicted = (p != ct[i]);
         e.c[i] = 1'b0;
         e.t[i] = ~ct[i];
         e.m[i] = ~mispredicted;
         e.a[i*32 +: 32] = ad;
      end
      n = 0;
      if (!br[0]) n++;
      if (!br[1]) n++;
      if (!fl) begin
         mq_a.delete();
         mq_p.delete();
      end else if (n > 0 && full_pre) begin
         m_err = 1'b1;
      end else begin
         if (!br[0]) begin mq_a.push_back(a0); mq_p.push_back(pt[0]); end
         if (!br[1]) begin mq_a.push_back(a1); mq_p.push_back(pt[1]); end
      end
      e.fl = mq_a.size() > DEPTH - SIMBRF;
      e.er = m_err;
      exp_q.push_back(e);
      txn++;
      $display("txn %0d: br_=%b com_br_=%b com_taken=%b flush_=%b", txn, br, cb, ct, fl);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(2'b11, '0, '0, 2'b00, 2'b11, 2'b00, 1'b1);
   endtask

   task automatic apply_reset();
      reset_ = 1'b0;
      bus.br_ = 2'b11; bus.br_addr = '0; bus.pred_taken = '0;
      bus.com_br_ = 2'b11; bus.com_taken = '0; bus.flush_ = 1'b1;
      mq_a.delete(); mq_p.delete(); exp_q.delete();
      m_err = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err}
          !== {6'h3f, 64'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL in_reset: got commit=%b taken=%b miss=%b addr=%h full=%b err=%b, expected 11/11/11/0/0/0",
                  bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err);
      end
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e, act;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         idle();
         e = exp_q.pop_front();
         act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
         checks++;
         if (act !== e) begin errors++; $display("FAIL reset_idle: got %h expected %h", act, e); end
      end
      checks++;
      if ({bus.br_commit_, bus.br_taken_, bus.br_pred_miss_} !== 6'h3f || bus.br_com_addr !== 64'h0 ||
          bus.full !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got commit=%b taken=%b miss=%b addr=%h full=%b err=%b",
                  bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err);
      end
   endtask

   task automatic test_basic();
      exp_t e, act;
      drive(2'b00, 32'hdeadbeef, 32'hdeadbfef, 2'b01, 2'b11, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL basic_push: got %h expected %h", act, e); end
      drive(2'b11, '0, '0, 2'b00, 2'b00, 2'b01, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL basic_commit: got %h expected %h", act, e); end
      checks++;
      if (bus.br_commit_ !== 2'b00 || bus.br_taken_ !== 2'b10 || bus.br_pred_miss_ !== 2'b11 ||
          bus.br_com_addr !== 64'hdeadbfef_deadbeef) begin
         errors++;
         $display("FAIL basic_values: got commit=%b taken=%b miss=%b addr=%h expected 00/10/11/deadbfefdeadbeef",
                  bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr);
      end
      idle();
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL basic_pulse_end: got %h expected %h", act, e); end
   endtask

   task automatic test_mispredict();
      exp_t e, act;
      drive(2'b10, 32'h0000_1234, '0, 2'b01, 2'b11, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL mispredict_push: got %h expected %h", act, e); end
      drive(2'b11, '0, '0, 2'b00, 2'b10, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL mispredict_commit: got %h expected %h", act, e); end
      checks++;
      if (bus.br_commit_ !== 2'b10 || bus.br_pred_miss_[0] !== 1'b0 || bus.br_taken_[0] !== 1'b1 ||
          bus.br_com_addr[31:0] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL mispredict_values: got commit=%b taken=%b miss=%b addr0=%h expected 10/x1/x0/00001234",
                  bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr[31:0]);
      end
   endtask

   // Gap compression: lone lane-1 push followed by lone lane-0 push become two
   // consecutive entries retired by commit lanes 0 and 1.
   task automatic test_lane_compress();
      exp_t e, act;
      drive(2'b01, 32'haaaa_0000, 32'h5555_0000, 2'b10, 2'b11, 2'b00, 1'b1);
      drive(2'b10, 32'h7777_0000, 32'h9999_0000, 2'b00, 2'b11, 2'b00, 1'b1);
      drive(2'b11, '0, '0, 2'b00, 2'b00, 2'b11, 1'b1);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         if (i == 2) begin
            act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
            checks++;
            if (act !== e) begin errors++; $display("FAIL compress_commit: got %h expected %h", act, e); end
         end
      end
      checks++;
      if (bus.br_com_addr !== 64'h7777_0000_5555_0000 || bus.br_pred_miss_ !== 2'b01) begin
         errors++;
         $display("FAIL compress_values: got addr=%h miss=%b expected 7777000055550000/01",
                  bus.br_com_addr, bus.br_pred_miss_);
      end
   endtask

   task automatic test_full();
      exp_t e, act;
      logic [31:0] base;
      base = 32'h1000_0000;
      for (int i = 0; i < 7; i++) begin
         drive(2'b00, base + 32'(i * 8), base + 32'(i * 8 + 4), 2'($urandom_range(0, 3)), 2'b11, 2'b00, 1'b1);
         e = exp_q.pop_front();
         act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
         checks++;
         if (act !== e) begin errors++; $display("FAIL full_fill%0d: got %h expected %h", i, act, e); end
      end
      // 14 of 16 used: two free entries, so not yet full.
      checks++;
      if (bus.full !== 1'b0) begin errors++; $display("FAIL full_at_14: got %b expected 0", bus.full); end
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, base + 32'h100 + 32'(i * 8), base + 32'h104 + 32'(i * 8), 2'($urandom_range(0, 3)),
               2'b00, 2'($urandom_range(0, 3)), 1'b1);
         e = exp_q.pop_front();
         act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
         checks++;
         if (act !== e) begin errors++; $display("FAIL full_b2b%0d: got %h expected %h", i, act, e); end
      end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL b2b_no_err: got %b expected 0", bus.err); end
      drive(2'b00, base + 32'h200, base + 32'h204, 2'b11, 2'b11, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL full_last_push: got %h expected %h", act, e); end
      checks++;
      if (bus.full !== 1'b1) begin errors++; $display("FAIL full_at_16: got %b expected 1", bus.full); end
      drive(2'b00, 32'hbad0_0000, 32'hbad0_0004, 2'b11, 2'b11, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL overflow_drop: got %h expected %h", act, e); end
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", bus.err); end
      for (int i = 0; i < 9; i++) begin
         drive(2'b11, '0, '0, 2'b00, 2'b00, 2'($urandom_range(0, 3)), 1'b1);
         e = exp_q.pop_front();
         act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
         checks++;
         if (act !== e) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, act, e); end
      end
   endtask

   task automatic test_flush();
      exp_t e, act;
      apply_reset();
      drive(2'b00, 32'h2000_0000, 32'h2000_0004, 2'b10, 2'b11, 2'b00, 1'b1);
      drive(2'b00, 32'h2000_0008, 32'h2000_000c, 2'b01, 2'b11, 2'b00, 1'b1);
      drive(2'b00, 32'h3000_0000, 32'h3000_0004, 2'b11, 2'b10, 2'b01, 1'b0);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         if (i == 2) begin
            act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
            checks++;
            if (act !== e) begin errors++; $display("FAIL flush_commit: got %h expected %h", act, e); end
         end
      end
      checks++;
      if (bus.br_commit_ !== 2'b10 || bus.br_com_addr[31:0] !== 32'h2000_0000 || bus.err !== 1'b0 ||
          bus.full !== 1'b0) begin
         errors++;
         $display("FAIL flush_values: got commit=%b addr0=%h err=%b full=%b expected 10/20000000/0/0",
                  bus.br_commit_, bus.br_com_addr[31:0], bus.err, bus.full);
      end
      drive(2'b11, '0, '0, 2'b00, 2'b10, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL flush_empty_commit: got %h expected %h", act, e); end
      checks++;
      if (bus.br_commit_ !== 2'b11 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty_values: got commit=%b err=%b expected 11/1", bus.br_commit_, bus.err);
      end
      drive(2'b10, 32'h4000_0000, '0, 2'b01, 2'b11, 2'b00, 1'b1);
      drive(2'b11, '0, '0, 2'b00, 2'b10, 2'b01, 1'b1);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         if (i == 1) begin
            act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
            checks++;
            if (act !== e) begin errors++; $display("FAIL flush_refill: got %h expected %h", act, e); end
         end
      end
   endtask

   task automatic test_underflow_async_reset();
      exp_t e, act;
      apply_reset();
      drive(2'b11, '0, '0, 2'b00, 2'b01, 2'b00, 1'b1);
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL underflow: got %h expected %h", act, e); end
      checks++;
      if (bus.br_commit_ !== 2'b11 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL underflow_values: got commit=%b err=%b expected 11/1", bus.br_commit_, bus.err);
      end
      drive(2'b00, 32'h5000_0000, 32'h5000_0004, 2'b01, 2'b11, 2'b00, 1'b1);
      drive(2'b11, '0, '0, 2'b00, 2'b00, 2'b10, 1'b1);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         if (i == 1) begin
            act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
            checks++;
            if (act !== e) begin errors++; $display("FAIL pre_reset_commit: got %h expected %h", act, e); end
         end
      end
      // Mid-cycle reset: outputs must clear with no clock edge in between.
      #2;
      reset_ = 1'b0;
      #1;
      checks++;
      if ({bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err}
          !== {6'h3f, 64'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got commit=%b taken=%b miss=%b addr=%h full=%b err=%b expected 11/11/11/0/0/0",
                  bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err);
      end
      apply_reset();
      idle();
      e = exp_q.pop_front();
      act = {bus.br_commit_, bus.br_taken_, bus.br_pred_miss_, bus.br_com_addr, bus.full, bus.err};
      checks++;
      if (act !== e) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", act, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_err = 1'b0;
      bus.br_ = 2'b11; bus.br_addr = '0; bus.pred_taken = '0;
      bus.com_br_ = 2'b11; bus.com_taken = '0; bus.flush_ = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_mispredict();
      test_lane_compress();
      test_full();
      test_flush();
      test_underflow_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
